// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared owner encoding and pipeline constants for the memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/mem_port_arbiter_fetch_buffer.sv
// mem_port_arbiter_fetch_buffer: one-entry hold for a fetched word while the pipeline is frozen
module mem_port_arbiter_fetch_buffer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] data_i,
    output logic            valid_o,
    output logic [XLEN-1:0] data_o
);
    logic            valid_q, valid_d;
    logic [XLEN-1:0] data_q, data_d;

    always_comb begin
        valid_d = clear_i ? 1'b0 : load_i ? 1'b1 : drain_i ? 1'b0 : valid_q;
        data_d  = load_i ? data_i : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [3:0]      mem_wmask,
    input  logic            flush,
    output logic            if_gnt,
    output logic            mem_gnt,
    output logic            mem_rvalid,
    output logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] instr_IFID,
    output logic            IFID_write,
    output logic            PC_stall,
    output logic            pipe_stall,
    output logic            m_en,
    output logic            m_we,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    output logic [3:0]      m_wmask,
    input  logic [XLEN-1:0] m_rdata
);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic          busy_q, busy_d, drop_q, drop_d;
    owner_e        owner_q, owner_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [SW-1:0] starve_q, starve_d;

    logic            done, free, if_done, if_take, fb_load, fb_drain;
    logic            if_elig, mem_want, force_if, fb_valid;
    logic [XLEN-1:0] fb_data;

    always_comb begin
        done       = busy_q && (lat_q == LW'(MEM_LAT - 1));
        free       = !busy_q || done;
        if_done    = done && owner_q == OWN_IF;
        mem_rvalid = done && owner_q == OWN_MEM;
        mem_rdata  = mem_rvalid ? m_rdata : '0;
        pipe_stall = mem_req && !mem_rvalid;
        // a flushed or dropped completion is wrong-path and never reaches IF/ID
        if_take    = if_done && !drop_q && !flush;
        fb_load    = if_take && pipe_stall;
        fb_drain   = fb_valid && !pipe_stall && !flush;
        // a word about to be buffered blocks the next fetch, so the buffer never overflows
        if_elig    = if_req && !fb_valid && !fb_load && !flush;
        mem_want   = mem_req && !(busy_q && owner_q == OWN_MEM);
        force_if   = if_elig && starve_q == SW'(STARVE_LIM);
        mem_gnt    = !rst && free && mem_want && !force_if;
        if_gnt     = !rst && free && if_elig && !mem_gnt;
        IFID_write = fb_drain || (if_take && !pipe_stall && !fb_valid);
        instr_IFID = fb_drain ? fb_data : IFID_write ? m_rdata : '0;
        PC_stall   = !IFID_write;
        m_en       = mem_gnt || if_gnt;
        m_we       = mem_gnt && mem_we;
        m_addr     = mem_gnt ? mem_addr : if_gnt ? if_addr : '0;
        m_wdata    = mem_gnt ? mem_wdata : '0;
        m_wmask    = mem_gnt ? mem_wmask : '0;
        busy_d     = m_en || (busy_q && !done);
        owner_d    = m_en ? (mem_gnt ? OWN_MEM : OWN_IF) : owner_q;
        lat_d      = (busy_q && !done && !m_en) ? lat_q + 1'b1 : '0;
        drop_d     = (flush && busy_q && owner_q == OWN_IF && !done) || (drop_q && !if_done);
        starve_d   = (if_gnt || !if_elig) ? '0 :
                     (mem_gnt && starve_q != SW'(STARVE_LIM)) ? starve_q + 1'b1 : starve_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            owner_q  <= OWN_IF;
            lat_q    <= '0;
            drop_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            lat_q    <= lat_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
        end
    end

    mem_port_arbiter_fetch_buffer #(.XLEN(XLEN)) u_fb (
        .clk     (clk),
        .rst     (rst),
        .load_i  (fb_load),
        .drain_i (fb_drain),
        .clear_i (flush),
        .data_i  (m_rdata),
        .valid_o (fb_valid),
        .data_o  (fb_data)
    );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the memory port arbiter at latency 1 and latency 3
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 0, mem_req = 0, mem_we = 0, flush = 0;
    logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
    logic [3:0]  mem_wmask = 0;
    logic        if_gnt1, mem_gnt1, mem_rvalid1, IFID_write1, PC_stall1, pipe_stall1, m_en1, m_we1;
    logic [31:0] mem_rdata1, instr1, m_addr1, m_wdata1, m_rdata1;
    logic [3:0]  m_wmask1;

    logic        if_req3 = 0, flush3 = 0;
    logic [31:0] if_addr3 = 0;
    logic        if_gnt3, mem_gnt3, mem_rvalid3, IFID_write3, PC_stall3, pipe_stall3, m_en3, m_we3;
    logic [31:0] mem_rdata3, instr3, m_addr3, m_wdata3, m_rdata3;
    logic [3:0]  m_wmask3;

    int errors = 0, checks = 0;
    logic [31:0] exp_instr[$], exp_mem[$];
    logic        o_if, o_mem, o_ifw, o_pcs, o_ps, o_rv, o_men, o_mwe, o3_if, o3_ifw;
    logic [31:0] o_instr, o_rd, o_maddr, o3_instr;

    always #5 clk = ~clk;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ NOP_INSTR;
    endfunction

    logic [31:0] a1, a3 [3];
    always @(posedge clk) begin
        a1    <= m_addr1;
        a3[0] <= m_addr3;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign m_rdata1 = mword(a1);
    assign m_rdata3 = mword(a3[2]);

    mem_port_arbiter #(.XLEN(32), .MEM_LAT(1), .STARVE_LIM(4)) u1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .flush(flush), .if_gnt(if_gnt1), .mem_gnt(mem_gnt1), .mem_rvalid(mem_rvalid1),
        .mem_rdata(mem_rdata1), .instr_IFID(instr1), .IFID_write(IFID_write1),
        .PC_stall(PC_stall1), .pipe_stall(pipe_stall1), .m_en(m_en1), .m_we(m_we1),
        .m_addr(m_addr1), .m_wdata(m_wdata1), .m_wmask(m_wmask1), .m_rdata(m_rdata1)
    );

    mem_port_arbiter #(.XLEN(32), .MEM_LAT(3), .STARVE_LIM(4)) u3 (
        .clk(clk), .rst(rst), .if_req(if_req3), .if_addr(if_addr3), .mem_req(1'b0),
        .mem_we(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0), .mem_wmask(4'h0),
        .flush(flush3), .if_gnt(if_gnt3), .mem_gnt(mem_gnt3), .mem_rvalid(mem_rvalid3),
        .mem_rdata(mem_rdata3), .instr_IFID(instr3), .IFID_write(IFID_write3),
        .PC_stall(PC_stall3), .pipe_stall(pipe_stall3), .m_en(m_en3), .m_we(m_we3),
        .m_addr(m_addr3), .m_wdata(m_wdata3), .m_wmask(m_wmask3), .m_rdata(m_rdata3)
    );

    // Scoreboard consumer: every delivered instruction and load result is popped in order.
    always @(negedge clk) begin
        #3;
        if (!rst && IFID_write1) begin
            checks++;
            if (exp_instr.size() == 0) begin
                errors++;
                $display("FAIL sb_instr unexpected IFID_write got=%h required=none", instr1);
            end else if (instr1 !== exp_instr[0]) begin
                errors++;
                $display("FAIL sb_instr got=%h required=%h", instr1, exp_instr[0]);
            end
            if (exp_instr.size() != 0) void'(exp_instr.pop_front());
        end
        if (!rst && mem_rvalid1) begin
            checks++;
            if (exp_mem.size() == 0) begin
                errors++;
                $display("FAIL sb_mem unexpected mem_rvalid got=%h required=none", mem_rdata1);
            end else if (mem_rdata1 !== exp_mem[0]) begin
                errors++;
                $display("FAIL sb_mem got=%h required=%h", mem_rdata1, exp_mem[0]);
            end
            if (exp_mem.size() != 0) void'(exp_mem.pop_front());
        end
    end

    // Inputs are driven right after a falling edge; tick samples 1 ns later and pushes expectations.
    task automatic tick;
        #1;
        o_if = if_gnt1; o_mem = mem_gnt1; o_ifw = IFID_write1; o_instr = instr1;
        o_pcs = PC_stall1; o_ps = pipe_stall1; o_rv = mem_rvalid1; o_rd = mem_rdata1;
        o_men = m_en1; o_mwe = m_we1; o_maddr = m_addr1;
        o3_if = if_gnt3; o3_ifw = IFID_write3; o3_instr = instr3;
        if (if_gnt1) exp_instr.push_back(mword(if_addr));
        if (mem_gnt1 && !mem_we) exp_mem.push_back(mword(mem_addr));
        @(negedge clk);
    endtask

    task automatic test_reset;
        mem_req = 1;
        tick();
        checks += 6;
        if (o_men !== 0 || o_mwe !== 0) begin errors++; $display("FAIL rst_m_en got=%b%b required=00", o_men, o_mwe); end
        if (o_ps !== 1) begin errors++; $display("FAIL rst_pipe_stall got=%b required=1", o_ps); end
        if (o_pcs !== 1) begin errors++; $display("FAIL rst_pc_stall got=%b required=1", o_pcs); end
        if (o_mem !== 0 || o_if !== 0) begin errors++; $display("FAIL rst_gnt got=%b%b required=00", o_mem, o_if); end
        if (o_instr !== 0 || o_rd !== 0) begin errors++; $display("FAIL rst_data got=%h/%h required=0", o_instr, o_rd); end
        if (o_maddr !== 0) begin errors++; $display("FAIL rst_m_addr got=%h required=0", o_maddr); end
        mem_req = 0; rst = 0; if_req = 1; if_addr = 32'h0;
        tick();
        checks++;
        if (o_if !== 1) begin errors++; $display("FAIL rst_first_gnt got=%b required=1", o_if); end
        rst = 1; exp_instr.delete();
        tick();
        checks += 2;
        if (o_men !== 0 || o_ifw !== 0) begin errors++; $display("FAIL rst_mid_fetch got=%b%b required=00", o_men, o_ifw); end
        if (o_pcs !== 1) begin errors++; $display("FAIL rst_mid_pc_stall got=%b required=1", o_pcs); end
        rst = 0;
        tick();
        checks++;
        if (o_if !== 1) begin errors++; $display("FAIL rst_refetch_gnt got=%b required=1", o_if); end
        if_req = 0;
        tick();
        checks++;
        if (o_ifw !== 1 || o_instr !== mword(32'h0)) begin errors++; $display("FAIL rst_refetch_data got=%b/%h required=1/%h", o_ifw, o_instr, mword(32'h0)); end
        tick();
    endtask

    task automatic test_stream;
        logic [31:0] pc = 32'h100;
        if_req = 1;
        for (int k = 0; k < 8; k++) begin
            if_addr = pc;
            tick();
            if (o_if) pc += 4;
            checks++;
            if (o_if !== 1 || (k > 0 && o_ifw !== 1)) begin
                errors++; $display("FAIL stream_cycle%0d got=gnt%b/wr%b required=gnt1/wr%0d", k, o_if, o_ifw, k > 0);
            end
        end
        if_req = 0;
        tick();
        checks++;
        if (o_ifw !== 1) begin errors++; $display("FAIL stream_last got=%b required=1", o_ifw); end
        tick();
    endtask

    task automatic test_load_collision;
        mem_req = 1; mem_we = 0; mem_addr = 32'h100; if_req = 1; if_addr = 32'h500;
        tick();
        checks++;
        if (o_mem !== 1 || o_if !== 0 || o_ps !== 1) begin
            errors++; $display("FAIL coll_first got=mem%b/if%b/ps%b required=1/0/1", o_mem, o_if, o_ps);
        end
        tick();
        checks += 2;
        if (o_rv !== 1 || o_rd !== mword(32'h100)) begin
            errors++; $display("FAIL coll_rdata got=%b/%h required=1/%h", o_rv, o_rd, mword(32'h100));
        end
        if (o_if !== 1 || o_ps !== 0 || o_mem !== 0) begin
            errors++; $display("FAIL coll_if_next got=if%b/ps%b/mem%b required=1/0/0", o_if, o_ps, o_mem);
        end
        mem_req = 0; if_req = 0;
        tick();
        checks++;
        if (o_ifw !== 1 || o_instr !== mword(32'h500)) begin
            errors++; $display("FAIL coll_fetch got=%b/%h required=1/%h", o_ifw, o_instr, mword(32'h500));
        end
        tick();
    endtask

    task automatic test_freeze;
        if_req = 1; if_addr = 32'h600;
        tick();
        checks++;
        if (o_if !== 1) begin errors++; $display("FAIL frz_gnt got=%b required=1", o_if); end
        if_addr = 32'h604; mem_req = 1; mem_addr = 32'h200;
        tick();
        checks++;
        if (o_ifw !== 0 || o_mem !== 1 || o_if !== 0 || o_ps !== 1) begin
            errors++; $display("FAIL frz_hold got=wr%b/mem%b/if%b/ps%b required=0/1/0/1", o_ifw, o_mem, o_if, o_ps);
        end
        tick();
        checks++;
        if (o_rv !== 1 || o_ifw !== 1 || o_instr !== mword(32'h600) || o_if !== 0) begin
            errors++; $display("FAIL frz_drain got=rv%b/wr%b/%h/if%b required=1/1/%h/0", o_rv, o_ifw, o_instr, o_if, mword(32'h600));
        end
        mem_req = 0;
        tick();
        checks++;
        if (o_if !== 1) begin errors++; $display("FAIL frz_regnt got=%b required=1", o_if); end
        if_req = 0;
        tick();
        checks++;
        if (o_ifw !== 1 || o_instr !== mword(32'h604)) begin
            errors++; $display("FAIL frz_next got=%b/%h required=1/%h", o_ifw, o_instr, mword(32'h604));
        end
        tick();
    endtask

    task automatic test_flush;
        rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 8; k++) begin
            if_req3 = (k <= 3); flush3 = (k == 1); if_addr3 = (k == 0) ? 32'h20 : 32'h40;
            tick();
            checks++;
            if (o3_ifw !== (k == 6)) begin errors++; $display("FAIL flush_wr_c%0d got=%b required=%0d", k, o3_ifw, k == 6); end
            if (k == 0 || k == 3) begin
                checks++;
                if (o3_if !== 1) begin errors++; $display("FAIL flush_gnt_c%0d got=%b required=1", k, o3_if); end
            end
            if (k == 6) begin
                checks++;
                if (o3_instr !== mword(32'h40)) begin errors++; $display("FAIL flush_data got=%h required=%h", o3_instr, mword(32'h40)); end
            end
        end
    endtask

    task automatic test_starvation;
        int run = 0, n_if = 0, n_mem = 0;
        logic pend = 0;
        logic [31:0] pc = 32'h800;
        mem_req = 1; mem_we = 0; mem_addr = 32'h300; if_req = 1;
        for (int k = 0; k < 24; k++) begin
            if_addr = pc;
            tick();
            if (o_if) begin pc += 4; run = 0; n_if++; end
            if (o_mem) begin run++; n_mem++; pend = 1; end
            if (o_rv) begin mem_addr += 4; pend = 0; end
            checks++;
            if (run > 4) begin errors++; $display("FAIL starve_run c%0d got=%0d required<=4", k, run); end
        end
        checks++;
        if (n_if < 4 || n_mem < 4) begin errors++; $display("FAIL starve_share got=if%0d/mem%0d required>=4 each", n_if, n_mem); end
        if_req = 0;
        for (int k = 0; k < 6; k++) begin
            mem_req = pend;
            tick();
            if (o_mem) pend = 1;
            if (o_rv) pend = 0;
        end
        mem_req = 0;
        tick();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_stream();
        test_load_collision();
        test_freeze();
        test_flush();
        test_starvation();
        checks += 2;
        if (exp_instr.size() != 0) begin errors++; $display("FAIL sb_instr_left got=%0d required=0", exp_instr.size()); end
        if (exp_mem.size() != 0) begin errors++; $display("FAIL sb_mem_left got=%0d required=0", exp_mem.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
